seq_multiplier: RTL

// Parametrised sequential radix-2 shift-add multiplier for the ALU MULTIPLIER slot.

---
 rtl/alu_pkg.sv | 16 +
 rtl/mul_addshift_dp.sv | 45 ++++
 rtl/seq_multiplier.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: multiplier FSM encoding and counter sizing helper.
package alu_pkg;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_CALC = 2'd1,
    MUL_FIX  = 2'd2,
    MUL_DONE = 2'd3
  } mul_state_t;

  // Width needed to count 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mul_addshift_dp.sv
// Radix-2 shift-add datapath: unsigned magnitudes in, 2N-bit unsigned accumulator out.
module mul_addshift_dp #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic [N-1:0]   a_mag,
  input  logic [N-1:0]   b_mag,
  output logic [2*N-1:0] acc
);

  logic [2*N-1:0] acc_r;
  logic [2*N-1:0] mcand_r;
  logic [N-1:0]   mplier_r;

  // Load clears the accumulator; each step adds the shifted multiplicand when the multiplier LSB is set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_r    <= '0;
      mcand_r  <= '0;
      mplier_r <= '0;
    end else if (load) begin
      acc_r    <= '0;
      mcand_r  <= {{N{1'b0}}, a_mag};
      mplier_r <= b_mag;
    end else if (step) begin
      if (mplier_r[0]) begin
        acc_r <= acc_r + mcand_r;
      end else begin
        acc_r <= acc_r;
      end
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
    end else begin
      acc_r    <= acc_r;
      mcand_r  <= mcand_r;
      mplier_r <= mplier_r;
    end
  end

  assign acc = acc_r;

endmodule

// File: rtl/seq_multiplier.sv
// Iterative N x N multiplier with start/busy/done handshake, signed/unsigned modes and overflow flag.
module seq_multiplier
  import alu_pkg::*;
#(
  parameter int N          = 16,
  parameter bit EARLY_ZERO = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [N-1:0]   a_in,
  input  logic [N-1:0]   b_in,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product,
  output logic [N-1:0]   out,
  output logic           overflow
);

  localparam int             CNT_W    = cnt_width(N);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);
  localparam logic [N-1:0]     ONE_N    = {{(N-1){1'b0}}, 1'b1};
  localparam logic [2*N-1:0]   ONE_2N   = {{(2*N-1){1'b0}}, 1'b1};

  mul_state_t       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             sign_r;
  logic             smode_r;
  logic             busy_r;
  logic             done_r;
  logic [2*N-1:0]   product_r;
  logic [N-1:0]     out_r;
  logic             overflow_r;

  logic             accept_s;
  logic             zero_s;
  logic             sign_s;
  logic [N-1:0]     a_mag_s;
  logic [N-1:0]     b_mag_s;
  logic [2*N-1:0]   acc_s;
  logic [2*N-1:0]   prod_s;
  logic             ovf_s;

  // Operand magnitudes; the most negative value wraps to 2^(N-1), which is its correct unsigned magnitude.
  always_comb begin
    a_mag_s  = a_in;
    b_mag_s  = b_in;
    if (signed_mode && a_in[N-1]) begin
      a_mag_s = ~a_in + ONE_N;
    end else begin
      a_mag_s = a_in;
    end
    if (signed_mode && b_in[N-1]) begin
      b_mag_s = ~b_in + ONE_N;
    end else begin
      b_mag_s = b_in;
    end
    sign_s   = signed_mode & (a_in[N-1] ^ b_in[N-1]);
    zero_s   = (a_in == '0) || (b_in == '0);
    accept_s = start && ((state_r == MUL_IDLE) || (state_r == MUL_DONE));
  end

  // Sign restore and range check on the finished accumulator.
  always_comb begin
    prod_s = acc_s;
    ovf_s  = 1'b0;
    if (sign_r) begin
      prod_s = ~acc_s + ONE_2N;
    end else begin
      prod_s = acc_s;
    end
    if (smode_r) begin
      ovf_s = !((&prod_s[2*N-1:N-1]) || !(|prod_s[2*N-1:N-1]));
    end else begin
      ovf_s = |prod_s[2*N-1:N];
    end
  end

  mul_addshift_dp #(.N(N)) u_dp (
    .clk   (clk),
    .rst   (rst),
    .load  (accept_s),
    .step  (state_r == MUL_CALC),
    .a_mag (a_mag_s),
    .b_mag (b_mag_s),
    .acc   (acc_s)
  );

  // Control FSM with registered handshake and result outputs; a zero operand skips straight to FIX.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= MUL_IDLE;
      cnt_r      <= '0;
      sign_r     <= 1'b0;
      smode_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      product_r  <= '0;
      out_r      <= '0;
      overflow_r <= 1'b0;
    end else begin
      case (state_r)
        MUL_IDLE, MUL_DONE: begin
          done_r <= 1'b0;
          if (accept_s) begin
            sign_r  <= sign_s;
            smode_r <= signed_mode;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
            if (EARLY_ZERO && zero_s) begin
              state_r <= MUL_FIX;
            end else begin
              state_r <= MUL_CALC;
            end
          end else begin
            state_r <= MUL_IDLE;
          end
        end
        MUL_CALC: begin
          cnt_r <= cnt_r + ONE_CNT;
          if (cnt_r == LAST_CNT) begin
            state_r <= MUL_FIX;
          end else begin
            state_r <= MUL_CALC;
          end
        end
        MUL_FIX: begin
          product_r  <= prod_s;
          out_r      <= prod_s[N-1:0];
          overflow_r <= ovf_s;
          busy_r     <= 1'b0;
          done_r     <= 1'b1;
          state_r    <= MUL_DONE;
        end
        default: begin
          state_r <= MUL_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign product  = product_r;
  assign out      = out_r;
  assign overflow = overflow_r;

endmodule
